// File: rtl/apb_req_bridge.sv
// Bridges a req/gnt/rvalid data port onto single APB3 master transfers, one outstanding at a time.
// Sub-word writes are answered with an error; define APB_BRIDGE_TIMEOUT_EN to abort hung ACCESS phases.
module apb_req_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, REJECT} state_e;

  state_e                    state_q, state_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;

  // Transfers are always word-aligned on APB; the low address bits are dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  assign gnt_o = (state_q == IDLE) && req_i;

  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          paddr_d  = {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
          pwdata_d = wdata_i;
          pwrite_d = we_i;
          state_d  = (we_i && be_i != 4'hF) ? REJECT : SETUP;
`ifdef APB_BRIDGE_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = pslverr_i;
          if (!pwrite_q) rdata_d = prdata_i;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        // Terminal wait cycle with no ready: give up and report an error.
        else if (cnt_q == TO_LAST) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      REJECT: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        err_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rvalid_o  = rvalid_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboarded bench for apb_req_bridge: APB slave model with programmable wait states,
// responses predicted at grant time and compared when rvalid_o fires.
module tb_apb_req_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, gnt, rvalid, err;
  logic [AW-1:0] addr, paddr;
  logic [3:0]    be;
  logic [DW-1:0] wdata, rdata, pwdata, prdata;
  logic          pwrite, psel, penable, pready, pslverr;

  always #5 clk = ~clk;

  apb_req_bridge #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
    .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // APB slave: pready after slv_wait wait states, or never while slv_stuck.
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  logic          slv_stuck = 1'b0;
  int            slv_wait = 0;
  int            acc_cnt = 0;

  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  assign pready  = psel && penable && !slv_stuck && (acc_cnt >= slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err && pready;

  logic [AW-1:0] exp_paddr = '0;
  logic [DW-1:0] exp_pwdata = '0;
  logic          exp_pwrite = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  int            psel_cyc = 0;
  int            pen_cyc = 0;
  int            rsp_cnt = 0;
  int            rsp_cyc = -1;
  int            g_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (psel) begin
        psel_cyc++;
        chk("paddr", paddr, exp_paddr);
        chk("pwdata", pwdata, exp_pwdata);
        chk("pwrite", pwrite, exp_pwrite);
      end
      if (penable) begin
        pen_cyc++;
        chk("penable_without_psel", psel, 1);
      end
      if (rvalid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (sb_q.size() == 0) chk("sb_empty_on_rvalid", 64'(sb_q.size()), 1);
        else begin
          mon_e = sb_q.pop_front();
          chk("rdata", rdata, mon_e.rdata);
          chk("err", err, mon_e.err);
        end
      end else begin
        chk("err_without_rvalid", err, 0);
      end
    end
  end

  // Present a request and hold it until granted; predicts the response at the grant.
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [3:0] b, input logic [DW-1:0] d);
    int n = 0;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    #1;
    while (!gnt && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!gnt) begin
      chk("gnt_timeout", gnt, 1);
      req = 1'b0;
      return;
    end
    g_cyc = cyc;
    psel_cyc = 0;
    pen_cyc = 0;
    exp_paddr = {a[AW-1:2], 2'b00};
    exp_pwdata = d;
    exp_pwrite = w;
    if (w && b != 4'hF) sb_q.push_back({last_rdata, 1'b1});
    else if (slv_stuck) begin
`ifdef APB_BRIDGE_TIMEOUT_EN
      sb_q.push_back({last_rdata, 1'b1});
`endif
    end else begin
      if (!w) last_rdata = slv_rdata;
      sb_q.push_back({last_rdata, slv_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_wait", 64'(rsp_cnt >= target), 1);
  endtask

  int g1, rc, n;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_gnt", gnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read
    slv_rdata = 32'hCAFE_0001; slv_wait = 0; slv_err = 1'b0;
    issue(32'h1A10_0004, 1'b0, 4'h0, 32'h0);
    req = 1'b0;
    wait_rsp(1);
    chk("t1_latency", 64'(rsp_cyc - g_cyc), 3);
    chk("t1_psel_cycles", 64'(psel_cyc), 2);
    chk("t1_penable_cycles", 64'(pen_cyc), 1);

    // Write with three wait states
    slv_wait = 3;
    issue(32'h1A10_1008, 1'b1, 4'hF, 32'h1234_5678);
    req = 1'b0;
    wait_rsp(2);
    chk("t2_penable_cycles", 64'(pen_cyc), 4);
    chk("t2_psel_cycles", 64'(psel_cyc), 5);
    chk("t2_latency", 64'(rsp_cyc - g_cyc), 6);

    // Sub-word write is rejected without touching the bus
    slv_wait = 0;
    issue(32'h1A10_2000, 1'b1, 4'h3, 32'hDEAD_BEEF);
    req = 1'b0;
    wait_rsp(3);
    chk("t3_psel_cycles", 64'(psel_cyc), 0);
    chk("t3_latency", 64'(rsp_cyc - g_cyc), 2);

    // Slave error
    slv_err = 1'b1; slv_rdata = 32'h5555_AAAA;
    issue(32'h1A10_000C, 1'b0, 4'h0, 32'h0);
    req = 1'b0;
    wait_rsp(4);
    slv_err = 1'b0;

    // Back-to-back with req held high
    slv_rdata = 32'h0BAD_F00D;
    issue(32'h1A10_0010, 1'b0, 4'h0, 32'h0);
    g1 = g_cyc;
    issue(32'h1A10_3004, 1'b1, 4'hF, 32'h0000_600D);
    req = 1'b0;
    chk("b2b_period", 64'(g_cyc - g1), 3);
    chk("b2b_rvalid_with_gnt", 64'(rsp_cyc), 64'(g_cyc));
    wait_rsp(6);

    // Mixed random traffic, unaligned addresses
    for (int i = 0; i < 4; i++) begin
      slv_wait = $urandom_range(0, 2);
      slv_rdata = $urandom;
      issue($urandom, i[0], 4'hF, $urandom);
      req = 1'b0;
      wait_rsp(7 + i);
    end

    // Reset in the middle of ACCESS
    slv_stuck = 1'b1;
    issue(32'h1A10_0020, 1'b0, 4'h0, 32'h0);
    req = 1'b0;
    n = 0;
    while (!penable && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_access", penable, 1);
    rc = rsp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_psel", psel, 0);
    chk("t5_penable", penable, 0);
    chk("t5_rvalid", rvalid, 0);
    sb_q.delete();
    last_rdata = '0;
    slv_stuck = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_rsp", 64'(rsp_cnt), 64'(rc));
    slv_rdata = 32'h7777_0123;
    issue(32'h1A10_0024, 1'b0, 4'h0, 32'h0);
    req = 1'b0;
    wait_rsp(rc + 1);

    // Hung slave
    slv_stuck = 1'b1;
    rc = rsp_cnt;
    issue(32'h1A10_0030, 1'b0, 4'h0, 32'h0);
    req = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    wait_rsp(rc + 1);
    chk("t6_penable_cycles", 64'(pen_cyc), 4);
    chk("t6_psel_cycles", 64'(psel_cyc), 5);
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("t6_psel_held", psel, 1);
    chk("t6_penable_held", penable, 1);
    chk("t6_no_rsp", 64'(rsp_cnt), 64'(rc));
`endif
    rst = 1'b1;
    slv_stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
